// File: rtl/otter_pkg.sv
// Shared OTTER pipeline types: memory access sizes, writeback source select
// and the registered M-to-W bundle.
package otter_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        ALU  = 2'b00,
        LOAD = 2'b01,
        PC4  = 2'b10
    } result_src_t;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  result_src;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [4:0]  rd;
        logic [31:0] pc_plus4;
        logic        misalign;
    } wb_bundle_t;

    // The reserved size encoding 11 behaves as a full word.
    function automatic mem_size_t to_mem_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Picks the addressed byte/half out of a memory read word and extends it
// to 32 bits; word loads pass straight through.
module load_formatter
    import otter_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  mem_size_t   size_i,
    input  logic        zext_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'b00:   byte_sel = rdata_i[7:0];
            2'b01:   byte_sel = rdata_i[15:8];
            2'b10:   byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            BYTE:    data_o = zext_i ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            HALF:    data_o = zext_i ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues data-memory requests, stalls the front of the pipe
// until ACK, and registers the M-to-W bundle with formatted load data.
module mem_access_stage
    import otter_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignM,
    output logic        StallM,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [3:0]  DMEM_BE,
    output logic [31:0] DMEM_WDATA,
    input  logic [31:0] DMEM_RDATA,
    input  logic        DMEM_ACK,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic        MisalignW
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_q;
    wb_bundle_t  wb_q, wb_d;
    mem_size_t   size;
    logic        is_load, is_store, memop, misalign;
    logic [1:0]  a_lo;
    logic [31:0] load_data;

    always_comb begin
        is_load  = (ResultSrcM == 2'(LOAD));
        is_store = MemWriteM;
        memop    = is_load | is_store;
        size     = to_mem_size(MemSizeM);
        a_lo     = ALUResultM[1:0];
        misalign = memop && (((size == HALF) && a_lo[0]) ||
                             ((size == WORD) && (a_lo != 2'b00)));
    end

    assign DMEM_REQ  = memop && !misalign && !RST &&
                       ((state_q == IDLE) || (state_q == WAIT));
    assign StallM    = DMEM_REQ && !DMEM_ACK;
    assign DMEM_WE   = MemWriteM;
    assign DMEM_ADDR = {ALUResultM[31:2], 2'b00};

    // Request fields depend only on the held M inputs, so they stay stable while stalled.
    always_comb begin
        DMEM_BE    = 4'b0000;
        DMEM_WDATA = 32'b0;
        if (is_store) begin
            case (size)
                BYTE: begin
                    DMEM_BE    = 4'b0001 << a_lo;
                    DMEM_WDATA = {4{WriteDataM[7:0]}};
                end
                HALF: begin
                    DMEM_BE    = 4'b0011 << a_lo;
                    DMEM_WDATA = {2{WriteDataM[15:0]}};
                end
                default: begin
                    DMEM_BE    = 4'b1111;
                    DMEM_WDATA = WriteDataM;
                end
            endcase
        end
    end

    load_formatter u_load_formatter (
        .rdata_i   (DMEM_RDATA),
        .addr_lo_i (a_lo),
        .size_i    (size),
        .zext_i    (MemSignM),
        .data_o    (load_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (DMEM_REQ && !DMEM_ACK) state_q <= WAIT;
                WAIT:    if (DMEM_ACK) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // A stalled cycle leaves wb_d at all-zero, which is the bubble.
    always_comb begin
        wb_d = '0;
        if (!StallM) begin
            wb_d.reg_write  = RegWriteM && !misalign;
            wb_d.result_src = ResultSrcM;
            wb_d.alu_result = ALUResultM;
            wb_d.rd         = RdM;
            wb_d.pc_plus4   = PCPlus4M;
            wb_d.misalign   = misalign;
            wb_d.read_data  = (is_load && !misalign) ? load_data : 32'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign RegWriteW  = wb_q.reg_write;
    assign ResultSrcW = wb_q.result_src;
    assign ALUResultW = wb_q.alu_result;
    assign ReadDataW  = wb_q.read_data;
    assign RdW        = wb_q.rd;
    assign PCPlus4W   = wb_q.pc_plus4;
    assign MisalignW  = wb_q.misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver pushes the expected W
// bundle for every cycle, a monitor pops and compares after each edge.
module tb_mem_access_stage;

    logic        CLK, RST;
    logic        RegWriteM, MemWriteM, MemSignM;
    logic [1:0]  ResultSrcM, MemSizeM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        StallM, DMEM_REQ, DMEM_WE, DMEM_ACK;
    logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
    logic [3:0]  DMEM_BE;
    logic        RegWriteW, MisalignW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;

    mem_access_stage dut (
        .CLK(CLK), .RST(RST),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .PCPlus4M(PCPlus4M), .MemSizeM(MemSizeM), .MemSignM(MemSignM),
        .StallM(StallM),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_BE(DMEM_BE), .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA),
        .DMEM_ACK(DMEM_ACK),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W), .MisalignW(MisalignW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        mis;
    } wexp_t;

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [1:0]  sz;
        logic        sg;
    } instr_t;

    wexp_t expq[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // Reference: pick n bytes starting at the byte offset, sign-extend by arithmetic.
    function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input int n, input int off, input logic zext);
        longint unsigned v, span;
        span = 64'd1 << (8 * n);
        v = (64'(rdata) >> (8 * off)) & (span - 1);
        if (!zext && n < 4 && v >= (span >> 1)) v = v - span;
        return v[31:0];
    endfunction

    function automatic wexp_t model(input instr_t t, input logic [31:0] rdata);
        wexp_t e;
        int n, off;
        bit load, memop, mis;
        n     = nbytes(t.sz);
        off   = int'(t.alu % 4);
        load  = (t.rs == 2'b01);
        memop = load || t.mw;
        mis   = memop && ((t.alu % n) != 0);
        e     = '0;
        e.rs  = t.rs;
        e.alu = t.alu;
        e.rd  = t.rd;
        e.pc4 = t.pc4;
        if (mis) begin
            e.mis = 1'b1;
        end else begin
            e.rw = t.rw;
            if (load) e.rdata = fmt_load(rdata, n, off, t.sg);
        end
        return e;
    endfunction

    function automatic wexp_t actual_w();
        return {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, MisalignW};
    endfunction

    always @(posedge CLK) begin : monitor
        wexp_t e;
        #1;
        if (mon_en) begin
            if (expq.size() == 0) begin
                chk("w_queue_underflow", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("w_bundle", actual_w(), e);
            end
        end
    end

    task automatic drive(input instr_t t);
        RegWriteM  = t.rw;
        ResultSrcM = t.rs;
        MemWriteM  = t.mw;
        ALUResultM = t.alu;
        WriteDataM = t.wd;
        RdM        = t.rd;
        PCPlus4M   = t.pc4;
        MemSizeM   = t.sz;
        MemSignM   = t.sg;
    endtask

    task automatic chk_req(input instr_t t);
        int n, off;
        logic [3:0]  be;
        logic [31:0] wdat;
        n    = nbytes(t.sz);
        off  = int'(t.alu % 4);
        be   = t.mw ? 4'(((1 << n) - 1) << off) : 4'd0;
        wdat = 32'd0;
        if (t.mw) begin
            if (n == 1)      wdat = 32'(t.wd[7:0]) * 32'h0101_0101;
            else if (n == 2) wdat = 32'(t.wd[15:0]) * 32'h0001_0001;
            else             wdat = t.wd;
        end
        chk("dmem_req", DMEM_REQ, 1);
        chk("dmem_addr", DMEM_ADDR, t.alu - (t.alu % 4));
        chk("dmem_we", DMEM_WE, t.mw);
        chk("dmem_be", DMEM_BE, be);
        chk("dmem_wdata", DMEM_WDATA, wdat);
    endtask

    task automatic issue(input instr_t t, input int delay, input logic [31:0] rdata);
        bit memop, mis;
        memop = (t.rs == 2'b01) || t.mw;
        mis   = memop && ((t.alu % nbytes(t.sz)) != 0);
        if (!memop || mis) begin
            @(negedge CLK);
            drive(t);
            DMEM_ACK   = 1'($urandom_range(0, 1));
            DMEM_RDATA = $urandom;
            expq.push_back(model(t, DMEM_RDATA));
            #1;
            chk("req_none", DMEM_REQ, 0);
            chk("stall_none", StallM, 0);
        end else begin
            for (int i = 0; i < delay; i++) begin
                @(negedge CLK);
                drive(t);
                DMEM_ACK   = 1'b0;
                DMEM_RDATA = $urandom;
                expq.push_back('0);
                #1;
                chk("stall_wait", StallM, 1);
                chk_req(t);
            end
            @(negedge CLK);
            drive(t);
            DMEM_ACK   = 1'b1;
            DMEM_RDATA = rdata;
            expq.push_back(model(t, rdata));
            #1;
            chk("stall_ack", StallM, 0);
            chk_req(t);
        end
    endtask

    function automatic instr_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                                  input logic [31:0] alu, input logic [31:0] wd,
                                  input logic [1:0] sz, input logic sg);
        instr_t t;
        t.rw = rw; t.rs = rs; t.mw = mw; t.alu = alu; t.wd = wd;
        t.rd = 5'(alu[6:2] + 5'd1); t.pc4 = alu ^ 32'h0000_1004; t.sz = sz; t.sg = sg;
        return t;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        instr_t t, zero;
        int kind, n;

        zero = mk(0, 2'b00, 0, 32'h0, 32'h0, 2'd0, 0);
        zero.rd = 5'd0; zero.pc4 = 32'h0;
        RST = 1'b1;
        drive(zero);
        DMEM_ACK = 1'b0;
        DMEM_RDATA = 32'h0;

        // Reset with a load presented: no request, no stall, W stays clear.
        t = mk(1, 2'b01, 0, 32'h0000_0040, 32'h0, 2'd2, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            drive(t);
            DMEM_ACK = 1'b0;
            expq.push_back('0);
            mon_en = 1'b1;
            #1;
            chk("rst_req", DMEM_REQ, 0);
            chk("rst_stall", StallM, 0);
        end
        @(negedge CLK);
        RST = 1'b0;
        drive(zero);
        expq.push_back('0);

        // Word load, same-cycle ACK.
        t = mk(1, 2'b01, 0, 32'h0000_0100, 32'h0, 2'd2, 0);
        issue(t, 0, 32'hDEAD_BEEF);
        @(posedge CLK); #2;
        chk("word_load_data", ReadDataW, 32'hDEAD_BEEF);
        chk("word_load_rw", RegWriteW, 1);

        // Byte load at lane 3, signed then unsigned.
        t = mk(1, 2'b01, 0, 32'h0000_0103, 32'h0, 2'd0, 0);
        issue(t, 1, 32'h80FF_FF7F);
        @(posedge CLK); #2;
        chk("byte_load_signed", ReadDataW, 32'hFFFF_FF80);
        t.sg = 1'b1;
        issue(t, 0, 32'h80FF_FF7F);
        @(posedge CLK); #2;
        chk("byte_load_unsigned", ReadDataW, 32'h0000_0080);

        // Half store at 0x22 with a 3-cycle ACK delay.
        t = mk(0, 2'b00, 1, 32'h0000_0022, 32'h0000_ABCD, 2'd1, 0);
        issue(t, 3, 32'h0);
        chk("half_store_be", DMEM_BE, 4'b1100);
        chk("half_store_wdata", DMEM_WDATA, 32'hABCD_ABCD);

        // Misaligned word load.
        t = mk(1, 2'b01, 0, 32'h0000_0102, 32'h0, 2'd2, 0);
        issue(t, 0, 32'h1234_5678);
        @(posedge CLK); #2;
        chk("misalign_flag", MisalignW, 1);
        chk("misalign_rw", RegWriteW, 0);

        // Reset during the second WAIT cycle, then a stray ACK.
        t = mk(1, 2'b01, 0, 32'h0000_0200, 32'h0, 2'd2, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            drive(t);
            DMEM_ACK = 1'b0;
            expq.push_back('0);
            #1;
            chk("pre_rst_stall", StallM, 1);
        end
        @(negedge CLK);
        RST = 1'b1;
        expq.push_back('0);
        #1;
        chk("mid_rst_req", DMEM_REQ, 0);
        chk("mid_rst_stall", StallM, 0);
        @(negedge CLK);
        RST = 1'b0;
        drive(zero);
        DMEM_ACK   = 1'b1;
        DMEM_RDATA = 32'hCAFE_F00D;
        expq.push_back('0);
        #1;
        chk("stray_ack_req", DMEM_REQ, 0);
        chk("stray_ack_stall", StallM, 0);

        // Randomized mix of ALU, PC+4, load and store instructions.
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 3));
            t = mk(1'($urandom_range(0, 1)), 2'b00, 0, $urandom, $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            t.rd  = 5'($urandom);
            t.pc4 = $urandom;
            case (kind)
                0: t.rs = 2'b00;
                1: t.rs = 2'b10;
                2: begin t.rs = 2'b01; t.rw = 1'b1; end
                default: begin t.rs = 2'b00; t.mw = 1'b1; t.rw = 1'b0; end
            endcase
            n = nbytes(t.sz);
            if ($urandom_range(0, 9) < 7) t.alu = t.alu - (t.alu % n);
            issue(t, int'($urandom_range(0, 3)), $urandom);
        end

        for (int i = 0; i < 3; i++) issue(zero, 0, 32'h0);
        @(posedge CLK); #2;
        mon_en = 1'b0;
        chk("queue_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
